keygen_div_div_13s_9ns_13_seq: RTL and testbench

Sequential signed-by-unsigned divider for the Falcon key-generation datapath. It is the inverse operator of the 13s×9ns pipelined multiplier. It takes a 13-bit signed dividend and a 9-bit unsigned divisor and returns a truncating (C-semantics) quotient and remainder after a fixed 14-cycle latency. It runs one restoring-division iteration per cycle, uses a start/ready/done handshake, and honours the shared `ce` stall like the other keygen arithmetic units.

---
 rtl/keygen_div_div_13s_9ns_13_seq_pkg.sv | 26 ++
 rtl/keygen_div_div_13s_9ns_13_seq_if.sv | 25 ++
 rtl/keygen_div_div_13s_9ns_13_seq_step.sv | 21 ++
 rtl/keygen_div_div_13s_9ns_13_seq.sv | 113 +++++++++++
 tb/tb_keygen_div_div_13s_9ns_13_seq.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/keygen_div_div_13s_9ns_13_seq_pkg.sv
// Shared constants, state encoding and helpers for the keygen 13s/9ns sequential divider.
package keygen_div_pkg;

  localparam int unsigned DIVIDEND_W = 13;
  localparam int unsigned DIVISOR_W  = 9;
  localparam int unsigned PREM_W     = 10;
  localparam int unsigned CNT_W      = 4;

  localparam logic [CNT_W-1:0]      ITER_FIRST = CNT_W'(DIVIDEND_W - 1);
  localparam logic [DIVIDEND_W-1:0] DBZ_QUOT   = 13'h1FFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Two's-complement negate when neg is set; -4096 maps onto itself.
  function automatic logic [DIVIDEND_W-1:0] cond_negate(
    input logic [DIVIDEND_W-1:0] v,
    input logic                  neg
  );
    return neg ? (~v + DIVIDEND_W'(1)) : v;
  endfunction

endpackage

// File: rtl/keygen_div_div_13s_9ns_13_seq_if.sv
// Handshake and data bundle between a requester and the keygen divider.
interface keygen_div_if;
  import keygen_div_pkg::*;

  logic                  ce;
  logic                  start;
  logic [DIVIDEND_W-1:0] din0;
  logic [DIVISOR_W-1:0]  din1;
  logic                  ready;
  logic                  done;
  logic [DIVIDEND_W-1:0] quot;
  logic [DIVIDEND_W-1:0] rem;
  logic                  dbz;

  modport master (
    output ce, start, din0, din1,
    input  ready, done, quot, rem, dbz
  );

  modport slave (
    input  ce, start, din0, din1,
    output ready, done, quot, rem, dbz
  );

endinterface

// File: rtl/keygen_div_div_13s_9ns_13_seq_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module keygen_div_step
  import keygen_div_pkg::*;
(
  input  logic [PREM_W-1:0]    i_prem,
  input  logic                 i_bit,
  input  logic [DIVISOR_W-1:0] i_divisor,
  output logic [PREM_W-1:0]    o_prem,
  output logic                 o_qbit
);

  logic [PREM_W:0] w_shift;

  // The compare uses the full shifted width; the subtraction only needs the low bits
  // because a kept result is always below the divisor.
  assign w_shift = {i_prem, i_bit};
  assign o_qbit  = (w_shift >= (PREM_W + 1)'(i_divisor));
  assign o_prem  = o_qbit ? (w_shift[PREM_W-1:0] - PREM_W'(i_divisor))
                          : w_shift[PREM_W-1:0];

endmodule

// File: rtl/keygen_div_div_13s_9ns_13_seq.sv
// Sequential 13s/9ns truncating divider, 14-cycle latency, ce-stallable.
// Define KEYGEN_DIV_REM_EN to build the remainder datapath; otherwise rem is tied to 0.
module keygen_div_div_13s_9ns_13_seq
  import keygen_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  keygen_div_if.slave bus
);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_qsh;
  logic [PREM_W-1:0]     r_prem;
  logic [DIVISOR_W-1:0]  r_div;
  logic                  r_neg;
  logic                  r_done;
  logic [DIVIDEND_W-1:0] r_quot;
  logic                  r_dbz;
`ifdef KEYGEN_DIV_REM_EN
  logic [DIVIDEND_W-1:0] r_din0;
  logic [DIVIDEND_W-1:0] r_rem;
  logic [DIVIDEND_W-1:0] w_rem_fix;
`endif

  logic [DIVIDEND_W-1:0] w_mag;
  logic [DIVIDEND_W-1:0] w_quot_fix;
  logic [PREM_W-1:0]     w_prem;
  logic                  w_qbit;
  logic                  w_div_zero;

  assign w_mag      = cond_negate(bus.din0, bus.din0[DIVIDEND_W-1]);
  assign w_div_zero = (r_div == '0);

  // r_qsh shifts the dividend magnitude out of its MSB while quotient bits enter at
  // the LSB, so after the last step it holds the unsigned quotient.
  keygen_div_step u_step (
    .i_prem    (r_prem),
    .i_bit     (r_qsh[DIVIDEND_W-1]),
    .i_divisor (r_div),
    .o_prem    (w_prem),
    .o_qbit    (w_qbit)
  );

  assign w_quot_fix = w_div_zero ? DBZ_QUOT : cond_negate(r_qsh, r_neg);
`ifdef KEYGEN_DIV_REM_EN
  assign w_rem_fix  = w_div_zero ? r_din0 : cond_negate(DIVIDEND_W'(r_prem), r_neg);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_qsh   <= '0;
      r_prem  <= '0;
      r_div   <= '0;
      r_neg   <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_dbz   <= 1'b0;
`ifdef KEYGEN_DIV_REM_EN
      r_din0  <= '0;
      r_rem   <= '0;
`endif
    end else if (bus.ce) begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_qsh   <= w_mag;
            r_div   <= bus.din1;
            r_neg   <= bus.din0[DIVIDEND_W-1];
            r_prem  <= '0;
            r_cnt   <= ITER_FIRST;
            r_state <= CALC;
`ifdef KEYGEN_DIV_REM_EN
            r_din0  <= bus.din0;
`endif
          end
        end
        CALC: begin
          r_prem <= w_prem;
          r_qsh  <= {r_qsh[DIVIDEND_W-2:0], w_qbit};
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_quot  <= w_quot_fix;
          r_dbz   <= w_div_zero;
          r_done  <= 1'b1;
          r_state <= IDLE;
`ifdef KEYGEN_DIV_REM_EN
          r_rem   <= w_rem_fix;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ready = (r_state == IDLE);
  assign bus.done  = r_done;
  assign bus.quot  = r_quot;
  assign bus.dbz   = r_dbz;
`ifdef KEYGEN_DIV_REM_EN
  assign bus.rem   = r_rem;
`else
  assign bus.rem   = '0;
`endif

endmodule

// File: tb/tb_keygen_div_div_13s_9ns_13_seq.sv
// Directed self-checking bench for the keygen sequential divider.
module tb_keygen_div_div_13s_9ns_13_seq;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  keygen_div_if bus ();

  keygen_div_div_13s_9ns_13_seq u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [12:0] exp_rem(input logic [12:0] r);
`ifdef KEYGEN_DIV_REM_EN
    return r;
`else
    return 13'h0000 & r;
`endif
  endfunction

  // Called just after a rising edge; returns just after the edge that raised done.
  task automatic run_div(input string tag, input logic [12:0] a, input logic [8:0] b,
                         input logic [12:0] eq, input logic [12:0] er, input logic ed);
    int unsigned lat;
    bit          seen;
    bus.start = 1'b1;
    bus.din0  = a;
    bus.din1  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_busy"}, 32'(bus.ready), 32'd0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) seen = 1'b1;
    end
    check({tag, "_lat"},   lat,              32'd14);
    check({tag, "_quot"},  32'(bus.quot),    32'(eq));
    check({tag, "_rem"},   32'(bus.rem),     32'(exp_rem(er)));
    check({tag, "_dbz"},   32'(bus.dbz),     32'(ed));
    check({tag, "_ready"}, 32'(bus.ready),   32'd1);
  endtask

  initial begin
    int unsigned lat;
    bit          seen;
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    bus.ce    = 1'b1;
    bus.start = 1'b0;
    bus.din0  = '0;
    bus.din1  = '0;
    #12;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_quot",  32'(bus.quot),  32'd0);
    check("rst_rem",   32'(bus.rem),   32'd0);
    check("rst_dbz",   32'(bus.dbz),   32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    run_div("p1000_7", 13'd1000, 9'd7, 13'd142, 13'd6, 1'b0);
    check("b2b_done_high", 32'(bus.done), 32'd1);
    run_div("n1000_7", 13'h1C18, 9'd7, 13'h1F72, 13'h1FFA, 1'b0);
    run_div("n4096_1", 13'h1000, 9'd1, 13'h1000, 13'h0000, 1'b0);
    run_div("p4095_511", 13'd4095, 9'd511, 13'd8, 13'd7, 1'b0);
    run_div("p100_0", 13'd100, 9'd0, 13'h1FFF, 13'd100, 1'b1);
    @(posedge clk); #1;
    check("done_pulse", 32'(bus.done), 32'd0);
    check("quot_hold",  32'(bus.quot), 32'h1FFF);
    check("dbz_hold",   32'(bus.dbz),  32'd1);

    // ce stall of 5 cycles after 6 iterations, plus an ignored start during CALC
    bus.start = 1'b1;
    bus.din0  = 13'd1000;
    bus.din1  = 9'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    bus.ce = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    bus.ce    = 1'b1;
    bus.start = 1'b1;
    bus.din0  = 13'd5;
    bus.din1  = 9'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat  = 12;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) seen = 1'b1;
    end
    check("ce_lat",  lat,               32'd19);
    check("ce_quot", 32'(bus.quot),     32'd142);
    check("ce_rem",  32'(bus.rem),      32'(exp_rem(13'd6)));
    check("ce_dbz",  32'(bus.dbz),      32'd0);
    bus.ce = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("ce_done_held", 32'(bus.done), 32'd1);
    bus.ce = 1'b1;
    @(posedge clk); #1;
    check("ce_done_clr", 32'(bus.done), 32'd0);

    // asynchronous reset in the middle of CALC
    bus.start = 1'b1;
    bus.din0  = 13'd1000;
    bus.din1  = 9'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    check("mrst_ready", 32'(bus.ready), 32'd1);
    check("mrst_done",  32'(bus.done),  32'd0);
    check("mrst_quot",  32'(bus.quot),  32'd0);
    check("mrst_rem",   32'(bus.rem),   32'd0);
    check("mrst_dbz",   32'(bus.dbz),   32'd0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    run_div("p4095_3", 13'd4095, 9'd3, 13'd1365, 13'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
